// File: rtl/i2s_dac_tx.sv
// DAC-side I2S / left-justified transmitter: buffers stereo pairs in a small FIFO and
// serialises them MSB-first onto aud_dacdat, following codec-mastered BCLK/LRCK.
module i2s_dac_tx #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int I2S_DELAY  = 1
) (
  input  logic                          ck,
  input  logic                          rst,
  input  logic                          write,
  input  logic [DATA_W-1:0]             writedata_left,
  input  logic [DATA_W-1:0]             writedata_right,
  output logic                          write_ready,
  input  logic                          aud_bclk,
  input  logic                          aud_daclrck,
  output logic                          aud_dacdat,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W);

  typedef enum logic [1:0] {WAIT_LEFT, DELAY, SHIFT, PAD} state_t;

  logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic lrck_s1_q, lrck_s2_q, lrck_q;
  logic bfall, boundary, left_bnd, right_bnd;

  logic [DATA_W-1:0] mem_l_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q, level_d;
  logic              push, pop, fifo_empty;

  state_t            state_q;
  logic [DATA_W-1:0] shreg_q, hold_r_q, load_word;
  logic [CW-1:0]     cnt_q;
  logic              dacdat_q, underflow_q;

  // Write handshake: a pair is taken on any ck edge where write && write_ready;
  // write_ready depends only on the registered level, never on write.
  assign write_ready = (level_q < DEPTH_L);
  assign fifo_empty  = (level_q == '0);
  assign push        = write && write_ready;
  assign pop         = left_bnd && !fifo_empty;

  assign bfall     = bclk_s3_q && !bclk_s2_q;
  assign boundary  = bfall && (lrck_s2_q != lrck_q);
  assign left_bnd  = boundary && !lrck_s2_q;
  assign right_bnd = boundary && lrck_s2_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // An empty FIFO at the left boundary sends a silent frame; the right half comes from hold_r.
  always_comb begin
    load_word = hold_r_q;
    if (left_bnd) load_word = fifo_empty ? '0 : mem_l_q[rd_ptr_q];
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      bclk_s1_q <= 1'b0;
      bclk_s2_q <= 1'b0;
      bclk_s3_q <= 1'b0;
      lrck_s1_q <= 1'b0;
      lrck_s2_q <= 1'b0;
      lrck_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      bclk_s1_q <= aud_bclk;
      bclk_s2_q <= bclk_s1_q;
      bclk_s3_q <= bclk_s2_q;
      lrck_s1_q <= aud_daclrck;
      lrck_s2_q <= lrck_s1_q;
      if (bfall) lrck_q <= lrck_s2_q;
      if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge ck) begin
    if (push) begin
      mem_l_q[wr_ptr_q] <= writedata_left;
      mem_r_q[wr_ptr_q] <= writedata_right;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q     <= WAIT_LEFT;
      shreg_q     <= '0;
      hold_r_q    <= '0;
      cnt_q       <= '0;
      dacdat_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= 1'b0;
      if (bfall) begin
        // A right boundary only restarts a channel once a left word has been framed.
        if (left_bnd || (right_bnd && state_q != WAIT_LEFT)) begin
          if (left_bnd) begin
            hold_r_q    <= fifo_empty ? '0 : mem_r_q[rd_ptr_q];
            underflow_q <= fifo_empty;
          end
          if (I2S_DELAY != 0) begin
            state_q  <= DELAY;
            shreg_q  <= load_word;
            dacdat_q <= 1'b0;
          end else begin
            state_q  <= SHIFT;
            dacdat_q <= load_word[DATA_W-1];
            shreg_q  <= {load_word[DATA_W-2:0], 1'b0};
            cnt_q    <= CW'(1);
          end
        end else begin
          case (state_q)
            WAIT_LEFT: dacdat_q <= 1'b0;
            DELAY: begin
              dacdat_q <= shreg_q[DATA_W-1];
              shreg_q  <= {shreg_q[DATA_W-2:0], 1'b0};
              cnt_q    <= CW'(1);
              state_q  <= SHIFT;
            end
            SHIFT: begin
              if (cnt_q == CNT_LAST) begin
                dacdat_q <= 1'b0;
                state_q  <= PAD;
              end else begin
                dacdat_q <= shreg_q[DATA_W-1];
                shreg_q  <= {shreg_q[DATA_W-2:0], 1'b0};
                cnt_q    <= cnt_q + CW'(1);
              end
            end
            default: dacdat_q <= 1'b0;
          endcase
        end
      end
    end
  end

  assign aud_dacdat = dacdat_q;
  assign underflow  = underflow_q;
  assign fifo_level = level_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: one I2S instance and one left-justified instance
// share BCLK/LRCK; frames are captured bit by bit and compared to hand-built words.
module tb_i2s_dac_tx;

  logic        ck = 1'b0;
  logic        rst, write, write_lj;
  logic [23:0] wl, wr, wl_lj, wr_lj;
  logic        aud_bclk, aud_daclrck;
  logic        ready, dacdat, uf;
  logic [2:0]  level;
  logic [1:0]  st;
  logic        ready_lj, dacdat_lj, uf_lj;
  logic [2:0]  level_lj;
  logic [1:0]  st_lj;

  int n_vec = 0;
  int n_miss = 0;
  int uf_cnt = 0;
  int uf0;
  logic [63:0] f0, f1;
  logic        d0, d1;

  // clock/reset block
  always #10 ck = ~ck;

  i2s_dac_tx #(.DATA_W(24), .FIFO_DEPTH(4), .I2S_DELAY(1)) u_i2s (
    .ck(ck), .rst(rst), .write(write), .writedata_left(wl), .writedata_right(wr),
    .write_ready(ready), .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
    .aud_dacdat(dacdat), .underflow(uf), .fifo_level(level), .dbg_state(st)
  );

  i2s_dac_tx #(.DATA_W(24), .FIFO_DEPTH(4), .I2S_DELAY(0)) u_lj (
    .ck(ck), .rst(rst), .write(write_lj), .writedata_left(wl_lj), .writedata_right(wr_lj),
    .write_ready(ready_lj), .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
    .aud_dacdat(dacdat_lj), .underflow(uf_lj), .fifo_level(level_lj), .dbg_state(st_lj)
  );

  always @(negedge ck) if (uf === 1'b1) uf_cnt++;

  // scoreboard check
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks: one BCLK period, 4 ck low then 4 ck high, data sampled at its end
  task automatic bit_period(input logic lr, output logic o0, output logic o1);
    aud_bclk = 1'b0;
    aud_daclrck = lr;
    repeat (4) @(negedge ck);
    aud_bclk = 1'b1;
    repeat (4) @(negedge ck);
    o0 = dacdat;
    o1 = dacdat_lj;
  endtask

  task automatic run_bits(input logic lr, input int n, inout logic [63:0] a0, inout logic [63:0] a1);
    logic b0, b1;
    for (int i = 0; i < n; i++) begin
      bit_period(lr, b0, b1);
      a0 = {a0[62:0], b0};
      a1 = {a1[62:0], b1};
    end
  endtask

  task automatic run_frame(output logic [63:0] o0, output logic [63:0] o1);
    logic [63:0] a0, a1;
    a0 = '0;
    a1 = '0;
    run_bits(1'b0, 32, a0, a1);
    run_bits(1'b1, 32, a0, a1);
    o0 = a0;
    o1 = a1;
  endtask

  task automatic write_pair(input logic [23:0] l, input logic [23:0] r);
    write = 1'b1;
    wl = l;
    wr = r;
    @(negedge ck);
    write = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b1; write = 1'b0; write_lj = 1'b0;
    wl = '0; wr = '0; wl_lj = '0; wr_lj = '0;
    aud_bclk = 1'b1; aud_daclrck = 1'b1;
    @(negedge ck);

    // 1: reset with BCLK toggling
    for (int i = 0; i < 8; i++) begin
      aud_bclk = ((i % 4) < 2) ? 1'b0 : 1'b1;
      @(negedge ck);
      chk("rst_outputs", {58'b0, dacdat, uf, ready, level}, {58'b0, 1'b0, 1'b0, 1'b1, 3'd0});
    end
    rst = 1'b0;
    aud_bclk = 1'b1;
    bit_period(1'b1, d0, d1);
    bit_period(1'b1, d0, d1);
    chk("idle_dacdat", {63'b0, dacdat}, 64'd0);

    // 2: single pair, I2S framing
    write_pair(24'hA50F3C, 24'h123456);
    chk("t2_level", {61'b0, level}, 64'd1);
    uf0 = uf_cnt;
    run_frame(f0, f1);
    chk("t2_left", {32'b0, f0[63:32]}, {32'b0, 1'b0, 24'hA50F3C, 7'b0});
    chk("t2_right", {32'b0, f0[31:0]}, {32'b0, 1'b0, 24'h123456, 7'b0});
    chk("t2_level_after", {61'b0, level}, 64'd0);
    chk("t2_no_uf", 64'(uf_cnt - uf0), 64'd0);

    // 3: empty FIFO, two frames
    uf0 = uf_cnt;
    run_frame(f0, f1);
    chk("t3_frame0", f0, 64'd0);
    run_frame(f0, f1);
    chk("t3_frame1", f0, 64'd0);
    chk("t3_uf_count", 64'(uf_cnt - uf0), 64'd2);

    // 4: overfill with BCLK idle
    for (int k = 1; k <= 5; k++) begin
      write = 1'b1;
      wl = 24'(k);
      wr = 24'h100000 + 24'(k);
      @(negedge ck);
      chk("t4_level", {61'b0, level}, (k < 4) ? 64'(k) : 64'd4);
      chk("t4_ready", {63'b0, ready}, (k < 4) ? 64'd1 : 64'd0);
    end
    write = 1'b0;
    uf0 = uf_cnt;
    for (int k = 1; k <= 4; k++) begin
      run_frame(f0, f1);
      chk("t4_frame", f0, {1'b0, 24'(k), 7'b0, 1'b0, 24'h100000 + 24'(k), 7'b0});
    end
    chk("t4_no_uf", 64'(uf_cnt - uf0), 64'd0);
    chk("t4_empty", {61'b0, level}, 64'd0);

    // 5: reset in the middle of the left word
    write_pair(24'hC3C3C3, 24'h5A5A5A);
    f0 = '0;
    f1 = '0;
    run_bits(1'b0, 11, f0, f1);
    chk("t5_pre_reset", {53'b0, f0[10:0]}, {53'b0, 11'b01100001111});
    rst = 1'b1;
    @(negedge ck);
    chk("t5_rst_dacdat", {63'b0, dacdat}, 64'd0);
    chk("t5_rst_level", {61'b0, level}, 64'd0);
    rst = 1'b0;
    write_pair(24'h0F0F0F, 24'hF0F0F0);
    f0 = '0;
    f1 = '0;
    run_bits(1'b0, 21, f0, f1);
    run_bits(1'b1, 32, f0, f1);
    chk("t5_silent", f0, 64'd0);
    run_frame(f0, f1);
    chk("t5_resume", f0, {1'b0, 24'h0F0F0F, 7'b0, 1'b0, 24'hF0F0F0, 7'b0});

    // 6: left-justified instance
    write_lj = 1'b1;
    wl_lj = 24'h800001;
    wr_lj = 24'h7FFFFE;
    @(negedge ck);
    write_lj = 1'b0;
    run_frame(f0, f1);
    chk("t6_msb_first_bclk", {63'b0, f1[63]}, 64'd1);
    chk("t6_lsb_bclk24", {63'b0, f1[40]}, 64'd1);
    chk("t6_frame", f1, {24'h800001, 8'h00, 24'h7FFFFE, 8'h00});

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
